// File: rtl/iob_pcie_tx_ctrl_if.sv
// RIFFA TX channel and TX FIFO read-port bundle for iob_pcie_tx_ctrl.
// The master modport is the sequencer's view; slave is the FIFO/RIFFA side.
interface iob_pcie_tx_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PCI_W  = 64
);
   logic              fifo_empty_i;
   logic [PCI_W-1:0]  fifo_data_i;
   logic              fifo_ren_o;
   logic              chnl_tx_o;
   logic              chnl_tx_last_o;
   logic [DATA_W-1:0] chnl_tx_len_o;
   logic [30:0]       chnl_tx_off_o;
   logic [PCI_W-1:0]  chnl_tx_data_o;
   logic              chnl_tx_data_valid_o;
   logic              chnl_tx_data_ren_i;
   logic              chnl_tx_ack_i;

   modport master (
      input  fifo_empty_i,
      input  fifo_data_i,
      input  chnl_tx_data_ren_i,
      input  chnl_tx_ack_i,
      output fifo_ren_o,
      output chnl_tx_o,
      output chnl_tx_last_o,
      output chnl_tx_len_o,
      output chnl_tx_off_o,
      output chnl_tx_data_o,
      output chnl_tx_data_valid_o
   );

   modport slave (
      output fifo_empty_i,
      output fifo_data_i,
      output chnl_tx_data_ren_i,
      output chnl_tx_ack_i,
      input  fifo_ren_o,
      input  chnl_tx_o,
      input  chnl_tx_last_o,
      input  chnl_tx_len_o,
      input  chnl_tx_off_o,
      input  chnl_tx_data_o,
      input  chnl_tx_data_valid_o
   );
endinterface

// File: rtl/iob_pcie_tx_ctrl.sv
// RIFFA TX channel sequencer: frames one transaction per start_i and streams ceil(LEN/2)
// 64-bit beats from the TX FIFO through a 2-entry buffer that hides the FIFO read latency.
module iob_pcie_tx_ctrl #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned C_PCI_DATA_W = 64,
   parameter int unsigned ACK_TIMEOUT  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [DATA_W-1:0] len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [DATA_W-1:0] beats_sent_o,
   iob_pcie_tx_ctrl_if.master bus
);

   typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

   localparam logic [31:0] AckLimit = 32'(ACK_TIMEOUT - 1);

   state_e                  state_q, state_d;
   logic                    chnl_tx_q, chnl_tx_d;
   logic [DATA_W-1:0]       len_q, len_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic [DATA_W-1:0]       beats_sent_q, beats_sent_d;
   logic [DATA_W-1:0]       beats_q, beats_d;
   logic [DATA_W-1:0]       fetch_left_q, fetch_left_d;
   logic [31:0]             timer_q, timer_d;
   logic [1:0]              occ_q, occ_d;
   logic                    inflight_q, inflight_d;
   logic [C_PCI_DATA_W-1:0] buf_q [2];
   logic [C_PCI_DATA_W-1:0] buf_d [2];

   logic              active;
   logic              valid;
   logic              consume;
   logic              arrival;
   logic              fifo_ren;
   logic              last_consume;
   logic              flush;
   logic [2:0]        pending;
   logic [1:0]        wr_base;
   logic [DATA_W-1:0] beats_calc;

   // Round up without widening: len=0xFFFFFFFF yields 0x80000000.
   assign beats_calc = (len_i >> 1) + DATA_W'(len_i[0]);

   assign active  = (state_q == StReq) || (state_q == StData);
   assign valid   = (occ_q != 2'd0) && (state_q == StData);
   assign consume = valid && bus.chnl_tx_data_ren_i;
   // Data returning after an abort lands while IDLE and is dropped.
   assign arrival = inflight_q && (state_q != StIdle);

   assign pending  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, consume};
   assign fifo_ren = active && (fetch_left_q != '0) && !bus.fifo_empty_i && (pending < 3'd2);

   assign last_consume = consume && ((beats_sent_q + DATA_W'(1)) == beats_q);

   // FSM next state and status.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      flush        = 1'b0;
      beats_d      = beats_q;
      timer_d      = timer_q;
      beats_sent_d = beats_sent_q + DATA_W'(consume);
      fetch_left_d = fetch_left_q - DATA_W'(fifo_ren);

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               beats_sent_d = '0;
               if (len_i != '0) begin
                  state_d      = StReq;
                  len_d        = len_i;
                  beats_d      = beats_calc;
                  fetch_left_d = beats_calc;
                  timer_d      = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StReq: begin
            timer_d = timer_q + 32'd1;
            if (bus.chnl_tx_ack_i) begin
               state_d = StData;
            end else if ((ACK_TIMEOUT != 0) && (timer_q == AckLimit)) begin
               state_d = StIdle;
               error_d = 1'b1;
               flush   = 1'b1;
            end
         end
         StData: begin
            if (last_consume) begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign chnl_tx_d  = (state_d == StReq) || (state_d == StData);
   assign inflight_d = fifo_ren;
   assign wr_base    = occ_q - {1'b0, consume};

   // Output buffer: shift on consume, arriving beat lands behind the surviving entries.
   always_comb begin
      buf_d = buf_q;
      occ_d = occ_q + {1'b0, arrival} - {1'b0, consume};
      if (consume) begin
         buf_d[0] = buf_q[1];
      end
      if (arrival) begin
         buf_d[wr_base[0]] = bus.fifo_data_i;
      end
      if (flush) begin
         occ_d    = 2'd0;
         buf_d[0] = '0;
         buf_d[1] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         chnl_tx_q    <= 1'b0;
         len_q        <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         beats_sent_q <= '0;
         beats_q      <= '0;
         fetch_left_q <= '0;
         timer_q      <= '0;
         occ_q        <= 2'd0;
         inflight_q   <= 1'b0;
         buf_q[0]     <= '0;
         buf_q[1]     <= '0;
      end else begin
         state_q      <= state_d;
         chnl_tx_q    <= chnl_tx_d;
         len_q        <= len_d;
         done_q       <= done_d;
         error_q      <= error_d;
         beats_sent_q <= beats_sent_d;
         beats_q      <= beats_d;
         fetch_left_q <= fetch_left_d;
         timer_q      <= timer_d;
         occ_q        <= occ_d;
         inflight_q   <= inflight_d;
         buf_q[0]     <= buf_d[0];
         buf_q[1]     <= buf_d[1];
      end
   end

   assign busy_o       = (state_q != StIdle);
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign beats_sent_o = beats_sent_q;

   assign bus.fifo_ren_o           = fifo_ren;
   assign bus.chnl_tx_o            = chnl_tx_q;
   assign bus.chnl_tx_last_o       = 1'b1;
   assign bus.chnl_tx_len_o        = len_q;
   assign bus.chnl_tx_off_o        = '0;
   assign bus.chnl_tx_data_o       = buf_q[0];
   assign bus.chnl_tx_data_valid_o = valid;

endmodule

// File: tb/tb_iob_pcie_tx_ctrl.sv
// Scoreboard bench for iob_pcie_tx_ctrl: expected beats queued at FIFO push time,
// a negedge monitor pops and compares every consumed beat.
module tb_iob_pcie_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [31:0] len_i;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic [31:0] beats_sent_o;

   iob_pcie_tx_ctrl_if #(.DATA_W(32), .PCI_W(64)) bus ();

   iob_pcie_tx_ctrl #(
      .DATA_W      (32),
      .C_PCI_DATA_W(64),
      .ACK_TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .error_o     (error_o),
      .beats_sent_o(beats_sent_o),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] fifo_q [$];
   logic [63:0] exp_q  [$];
   int          cons_cyc [$];

   int   cyc       = 0;
   int   ren_cnt   = 0;
   int   cons_cnt  = 0;
   int   valid_cnt = 0;
   int   done_cnt  = 0;
   int   err_cnt   = 0;
   int   tx_cnt    = 0;
   logic ren_seen  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: everything is sampled mid-cycle, the consume happens on the following posedge.
   always @(negedge clk) begin
      cyc++;
      ren_seen = bus.fifo_ren_o;
      if (bus.fifo_ren_o) begin
         ren_cnt++;
         check("fifo_ren_on_nonempty", 64'(bus.fifo_empty_i), 64'd0);
      end
      if (bus.chnl_tx_data_valid_o) valid_cnt++;
      if (done_o) done_cnt++;
      if (error_o) err_cnt++;
      if (bus.chnl_tx_o) tx_cnt++;
      if (bus.chnl_tx_data_valid_o && bus.chnl_tx_data_ren_i) begin
         cons_cnt++;
         cons_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_unexpected: got 0x%0h, want no beat", bus.chnl_tx_data_o);
         end else begin
            check("beat_data", bus.chnl_tx_data_o, exp_q.pop_front());
         end
      end
   end

   // All DUT inputs and the FIFO model are updated only here, 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (ren_seen && fifo_q.size() > 0) bus.fifo_data_i = fifo_q.pop_front();
      bus.fifo_empty_i = (fifo_q.size() == 0);
   endtask

   task automatic push_fifo(input logic [63:0] d, input bit expected);
      fifo_q.push_back(d);
      if (expected) exp_q.push_back(d);
      bus.fifo_empty_i = 1'b0;
   endtask

   task automatic clear_fifo();
      fifo_q.delete();
      bus.fifo_empty_i = 1'b1;
   endtask

   task automatic start_txn(input logic [31:0] len);
      start_i = 1'b1;
      len_i   = len;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_tx_high(input string name);
      int n = 0;
      while (!bus.chnl_tx_o && n < 20) begin
         tick();
         n++;
      end
      check(name, 64'(bus.chnl_tx_o), 64'd1);
   endtask

   task automatic pulse_ack(input int delay);
      repeat (delay) tick();
      bus.chnl_tx_ack_i = 1'b1;
      tick();
      bus.chnl_tx_ack_i = 1'b0;
   endtask

   task automatic wait_idle(input string name, input bit toggle_ren);
      int n = 0;
      while (busy_o && n < 300) begin
         if (toggle_ren) bus.chnl_tx_data_ren_i = ~bus.chnl_tx_data_ren_i;
         tick();
         n++;
      end
      check(name, 64'(busy_o), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, want end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0, c0, r0, t0, v0, n0, n;

      rst                     = 1'b1;
      start_i                 = 1'b0;
      len_i                   = '0;
      bus.fifo_empty_i        = 1'b1;
      bus.fifo_data_i         = '0;
      bus.chnl_tx_data_ren_i  = 1'b0;
      bus.chnl_tx_ack_i       = 1'b0;
      repeat (3) tick();

      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_error", 64'(error_o), 64'd0);
      check("rst_beats_sent", 64'(beats_sent_o), 64'd0);
      check("rst_chnl_tx", 64'(bus.chnl_tx_o), 64'd0);
      check("rst_last", 64'(bus.chnl_tx_last_o), 64'd1);
      check("rst_len", 64'(bus.chnl_tx_len_o), 64'd0);
      check("rst_valid", 64'(bus.chnl_tx_data_valid_o), 64'd0);
      check("rst_ren", 64'(bus.fifo_ren_o), 64'd0);
      rst = 1'b0;
      tick();

      // T4: no ack, prefetched beats must be flushed and never reach the next transaction.
      d0 = done_cnt; e0 = err_cnt;
      for (int i = 0; i < 3; i++) push_fifo(64'hDEAD_0000_0000_0000 + 64'(i), 1'b0);
      start_txn(32'd6);
      wait_tx_high("t4_chnl_tx_rise");
      n = 0;
      while (bus.chnl_tx_o && n < 40) begin
         tick();
         n++;
      end
      check("t4_req_cycles", 64'(n), 64'd16);
      check("t4_error_pulse", 64'(error_o), 64'd1);
      check("t4_busy", 64'(busy_o), 64'd0);
      repeat (3) tick();
      check("t4_error_count", 64'(err_cnt - e0), 64'd1);
      check("t4_no_done", 64'(done_cnt - d0), 64'd0);
      clear_fifo();
      tick();

      // T1: len=8, four preloaded beats, ack 3 cycles after chnl_tx, ren held high.
      d0 = done_cnt; c0 = cons_cnt; n0 = cons_cyc.size();
      for (int i = 0; i < 4; i++) push_fifo(64'h1111_0000_0000_0000 + 64'(i), 1'b1);
      bus.chnl_tx_data_ren_i = 1'b1;
      start_txn(32'd8);
      wait_tx_high("t1_chnl_tx_rise");
      check("t1_len", 64'(bus.chnl_tx_len_o), 64'd8);
      check("t1_off", 64'(bus.chnl_tx_off_o), 64'd0);
      check("t1_last", 64'(bus.chnl_tx_last_o), 64'd1);
      pulse_ack(3);
      wait_idle("t1_idle", 1'b0);
      check("t1_beats", 64'(cons_cnt - c0), 64'd4);
      if (cons_cyc.size() >= n0 + 4)
         check("t1_back_to_back", 64'(cons_cyc[n0+3] - cons_cyc[n0]), 64'd3);
      check("t1_done_count", 64'(done_cnt - d0), 64'd1);
      check("t1_beats_sent", 64'(beats_sent_o), 64'd4);
      check("t1_scoreboard_empty", 64'(exp_q.size()), 64'd0);

      // T2: len=5 -> 3 beats, a 4th FIFO entry must not be read, ren toggles.
      c0 = cons_cnt; r0 = ren_cnt;
      for (int i = 0; i < 3; i++) push_fifo(64'h2222_0000_0000_0000 + 64'(i), 1'b1);
      push_fifo(64'h2222_FFFF_FFFF_FFFF, 1'b0);
      start_txn(32'd5);
      wait_tx_high("t2_chnl_tx_rise");
      pulse_ack(1);
      wait_idle("t2_idle", 1'b1);
      check("t2_beats", 64'(cons_cnt - c0), 64'd3);
      check("t2_fifo_reads", 64'(ren_cnt - r0), 64'd3);
      check("t2_beats_sent", 64'(beats_sent_o), 64'd3);
      clear_fifo();
      bus.chnl_tx_data_ren_i = 1'b1;
      tick();

      // T3: FIFO empty at ack, one beat pushed every 5 cycles.
      c0 = cons_cnt; v0 = valid_cnt; r0 = ren_cnt;
      start_txn(32'd6);
      wait_tx_high("t3_chnl_tx_rise");
      pulse_ack(2);
      for (int i = 0; i < 3; i++) begin
         repeat (5) tick();
         push_fifo(64'h3333_0000_0000_0000 + 64'(i), 1'b1);
      end
      wait_idle("t3_idle", 1'b0);
      check("t3_beats", 64'(cons_cnt - c0), 64'd3);
      check("t3_valid_cycles", 64'(valid_cnt - v0), 64'd3);
      check("t3_fifo_reads", 64'(ren_cnt - r0), 64'd3);

      // T5: zero length completes without touching the channel.
      d0 = done_cnt; t0 = tx_cnt; r0 = ren_cnt;
      start_txn(32'd0);
      check("t5_done_pulse", 64'(done_o), 64'd1);
      check("t5_busy", 64'(busy_o), 64'd0);
      repeat (3) tick();
      check("t5_done_count", 64'(done_cnt - d0), 64'd1);
      check("t5_no_chnl_tx", 64'(tx_cnt - t0), 64'd0);
      check("t5_no_fifo_read", 64'(ren_cnt - r0), 64'd0);
      check("t5_beats_sent", 64'(beats_sent_o), 64'd0);

      // T6: reset after 2 of 4 beats, then a len=2 transaction.
      c0 = cons_cnt;
      for (int i = 0; i < 4; i++) push_fifo(64'h6666_0000_0000_0000 + 64'(i), 1'b1);
      start_txn(32'd8);
      wait_tx_high("t6_chnl_tx_rise");
      pulse_ack(1);
      n = 0;
      while ((cons_cnt - c0) < 2 && n < 50) begin
         tick();
         n++;
      end
      check("t6_two_beats", 64'(cons_cnt - c0), 64'd2);
      d0 = done_cnt; e0 = err_cnt;
      rst = 1'b1;
      bus.chnl_tx_data_ren_i = 1'b0;
      tick();
      check("t6_rst_chnl_tx", 64'(bus.chnl_tx_o), 64'd0);
      check("t6_rst_busy", 64'(busy_o), 64'd0);
      check("t6_rst_valid", 64'(bus.chnl_tx_data_valid_o), 64'd0);
      check("t6_rst_beats_sent", 64'(beats_sent_o), 64'd0);
      check("t6_rst_len", 64'(bus.chnl_tx_len_o), 64'd0);
      clear_fifo();
      exp_q.delete();
      rst = 1'b0;
      tick();
      check("t6_no_pulses", 64'((done_cnt - d0) + (err_cnt - e0)), 64'd0);
      d0 = done_cnt; c0 = cons_cnt;
      push_fifo(64'h6666_AAAA_0000_0001, 1'b1);
      bus.chnl_tx_data_ren_i = 1'b1;
      start_txn(32'd2);
      wait_tx_high("t6b_chnl_tx_rise");
      pulse_ack(2);
      wait_idle("t6b_idle", 1'b0);
      check("t6b_beats", 64'(cons_cnt - c0), 64'd1);
      check("t6b_done_count", 64'(done_cnt - d0), 64'd1);
      check("t6b_beats_sent", 64'(beats_sent_o), 64'd1);
      check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
